parallel_from_wide_bus_data_reader: RTL and testbench

Receive side of the SD 4-bit wide-bus data block transfer. Samples DAT[3:0] after a start nibble, deserialises one data block (default 512 bytes, 1024 nibbles) into a parallel word, checks one CRC16 per line and the end bit, then reports completion and error status. It is the counterpart of the wide-bus data writer and sits between the card DAT pads and the block buffer of the SD host / card model.

---
 rtl/parallel_from_wide_bus_data_reader.sv | 189 ++++++++++++++++++
 tb/tb_parallel_from_wide_bus_data_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/parallel_from_wide_bus_data_reader.sv
// Receive side of the SD wide-bus data block transfer.
// Waits for an all-zero start nibble on DAT, deserialises one block MSB-first
// into OUTPUTDATA, checks one CRC16 per DAT line plus the end nibble, and
// reports completion, CRC, end-bit and timeout status until ENA is dropped.
module parallel_from_wide_bus_data_reader #(
    parameter int blockSize     = 4095,
    parameter int CRCWidth      = 15,
    parameter int busWidth      = 3,
    parameter int timeoutCycles = 65535
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENA,
    input  logic [busWidth:0]    INPUTBUS,
    output logic [blockSize:0]   OUTPUTDATA,
    output logic                 COMPLT,
    output logic                 BUSY,
    output logic [busWidth:0]    CRCERR,
    output logic                 ENDERR,
    output logic                 TIMEOUT
);

    localparam int BUS_N     = busWidth + 1;
    localparam int NIBBLES   = (blockSize + 1) / BUS_N;
    localparam int NIB_W     = ($clog2(NIBBLES) + 1 > 12) ? $clog2(NIBBLES) + 1 : 12;
    localparam int CRC_N     = CRCWidth + 1;
    localparam int CRC_CNT_W = $clog2(CRC_N) + 1;
    localparam int IDX_W     = $clog2(blockSize + 1);

    localparam logic [NIB_W-1:0]     LAST_NIB = NIB_W'(NIBBLES - 1);
    localparam logic [CRC_CNT_W-1:0] LAST_CRC = CRC_CNT_W'(CRCWidth);
    localparam logic [15:0]          WAIT_LIM = 16'(timeoutCycles);
    localparam logic [CRCWidth:0]    CRC_POLY = CRC_N'(32'h1021);
    localparam logic [busWidth:0]    BUS_IDLE = '1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        DATA,
        CRC,
        ENDBIT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [NIB_W-1:0]     nib_cnt;
    logic [CRC_CNT_W-1:0] crc_cnt;
    logic [15:0]          wait_cnt;
    logic [IDX_W-1:0]     wr_base;
    logic [CRCWidth:0]    crc_calc [BUS_N];
    logic [CRCWidth:0]    crc_rx   [BUS_N];
    logic [busWidth:0]    crc_mismatch;
    logic                 start_seen;
    logic                 wait_expired;

    // One serial step of the x^16+x^12+x^5+1 generator, MSB first.
    function automatic logic [CRCWidth:0] crc_step(input logic [CRCWidth:0] crc,
                                                   input logic din);
        logic fb;
        fb       = crc[CRCWidth] ^ din;
        crc_step = {crc[CRCWidth-1:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

    // Bus decode: start nibble, wait expiry, write position and CRC compare.
    always_comb begin
        start_seen   = (INPUTBUS == '0);
        wait_expired = (wait_cnt >= WAIT_LIM);
        wr_base      = IDX_W'(blockSize) - IDX_W'(BUS_N) * IDX_W'(nib_cnt);
        crc_mismatch = '0;
        for (int n = 0; n < BUS_N; n++) begin
            crc_mismatch[n] = (crc_rx[n] != crc_calc[n]);
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; dropping ENA always returns to IDLE, and a start
    // nibble takes priority over an expiring wait.
    always_comb begin
        state_next = state;
        if (!ENA) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:       state_next = WAIT_START;
                WAIT_START: begin
                    if (start_seen) begin
                        state_next = DATA;
                    end else if (wait_expired) begin
                        state_next = DONE;
                    end
                end
                DATA:       if (nib_cnt == LAST_NIB) state_next = CRC;
                CRC:        if (crc_cnt == LAST_CRC) state_next = ENDBIT;
                ENDBIT:     state_next = DONE;
                DONE:       state_next = DONE;
                default:    state_next = IDLE;
            endcase
        end
    end

    // Datapath: counters, block deserialiser and per-line CRC registers.
    // OUTPUTDATA keeps partial contents when the transfer is abandoned.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUTPUTDATA <= '0;
            nib_cnt    <= '0;
            crc_cnt    <= '0;
            wait_cnt   <= '0;
            for (int n = 0; n < BUS_N; n++) begin
                crc_calc[n] <= '0;
                crc_rx[n]   <= '0;
            end
        end else if (!ENA || state == IDLE) begin
            nib_cnt  <= '0;
            crc_cnt  <= '0;
            wait_cnt <= '0;
            for (int n = 0; n < BUS_N; n++) begin
                crc_calc[n] <= '0;
                crc_rx[n]   <= '0;
            end
        end else begin
            case (state)
                WAIT_START: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    nib_cnt  <= '0;
                end
                DATA: begin
                    OUTPUTDATA[wr_base -: BUS_N] <= INPUTBUS;
                    nib_cnt <= nib_cnt + NIB_W'(1);
                    crc_cnt <= '0;
                    for (int n = 0; n < BUS_N; n++) begin
                        crc_calc[n] <= crc_step(crc_calc[n], INPUTBUS[n]);
                    end
                end
                CRC: begin
                    crc_cnt <= crc_cnt + CRC_CNT_W'(1);
                    for (int n = 0; n < BUS_N; n++) begin
                        crc_rx[n] <= {crc_rx[n][CRCWidth-1:0], INPUTBUS[n]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags: set by the FSM phases, all cleared as soon as ENA drops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            COMPLT  <= 1'b0;
            BUSY    <= 1'b0;
            CRCERR  <= '0;
            ENDERR  <= 1'b0;
            TIMEOUT <= 1'b0;
        end else if (!ENA) begin
            COMPLT  <= 1'b0;
            BUSY    <= 1'b0;
            CRCERR  <= '0;
            ENDERR  <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            case (state)
                WAIT_START: begin
                    if (start_seen) begin
                        BUSY <= 1'b1;
                    end else if (wait_expired) begin
                        TIMEOUT <= 1'b1;
                    end
                end
                ENDBIT: begin
                    ENDERR <= (INPUTBUS != BUS_IDLE);
                    CRCERR <= crc_mismatch;
                    BUSY   <= 1'b0;
                end
                DONE:    COMPLT <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_parallel_from_wide_bus_data_reader.sv
// Directed bench for the wide-bus block reader: clean blocks, CRC and end-bit
// errors, start timeout and an asynchronous reset in the middle of a block.
module tb_parallel_from_wide_bus_data_reader;

    localparam int NIB = 1024;
    localparam int TO  = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [3:0]    bus;
    logic [4095:0] dout;
    logic          complt;
    logic          busy;
    logic [3:0]    crcerr;
    logic          enderr;
    logic          tmo;

    int checks = 0;
    int errors = 0;

    logic [3:0]    blk [NIB];
    logic [15:0]   crc_tx [4];
    logic [3:0]    end_nib;
    logic [4095:0] exp_data;

    parallel_from_wide_bus_data_reader #(
        .blockSize    (4095),
        .CRCWidth     (15),
        .busWidth     (3),
        .timeoutCycles(TO)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .ENA       (ena),
        .INPUTBUS  (bus),
        .OUTPUTDATA(dout),
        .COMPLT    (complt),
        .BUSY      (busy),
        .CRCERR    (crcerr),
        .ENDERR    (enderr),
        .TIMEOUT   (tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference CRC16 (x^16+x^12+x^5+1, init 0) of one DAT line over the block.
    function automatic logic [15:0] crc_model(input int line);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int k = 0; k < NIB; k++) begin
            fb = c[15] ^ blk[k][line];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic prepare(input bit ordered);
        for (int k = 0; k < NIB; k++) begin
            blk[k] = ordered ? 4'(k) : 4'h0;
        end
        exp_data = '0;
        for (int k = 0; k < NIB; k++) begin
            exp_data = {exp_data[4091:0], blk[k]};
        end
        for (int n = 0; n < 4; n++) begin
            crc_tx[n] = crc_model(n);
        end
        end_nib = 4'hF;
    endtask

    task automatic send_block(input int abort_at, input logic [3:0] exp_crcerr,
                              input logic exp_enderr, input string tag);
        @(negedge clk);
        ena = 1'b1;
        bus = 4'hF;
        @(negedge clk);
        bus = 4'h0;
        @(posedge clk);
        #1;
        chk({tag, "_busy_rise"}, busy, 1);
        for (int k = 0; k < NIB; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                chk({tag, "_busy_mid"}, busy, 1);
                rst = 1'b1;
                #1;
                chk({tag, "_rst_data"}, 64'(|dout), 0);
                chk({tag, "_rst_busy"}, busy, 0);
                chk({tag, "_rst_complt"}, complt, 0);
                chk({tag, "_rst_crcerr"}, crcerr, 0);
                @(negedge clk);
                rst = 1'b0;
                ena = 1'b0;
                bus = 4'hF;
                return;
            end
            bus = blk[k];
        end
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            bus = {crc_tx[3][15-j], crc_tx[2][15-j], crc_tx[1][15-j], crc_tx[0][15-j]};
        end
        @(negedge clk);
        bus = end_nib;
        @(posedge clk);
        #1;
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_crcerr"}, crcerr, exp_crcerr);
        chk({tag, "_enderr"}, enderr, exp_enderr);
        chk({tag, "_complt_early"}, complt, 0);
        @(negedge clk);
        bus = 4'hF;
        @(posedge clk);
        #1;
        chk({tag, "_complt"}, complt, 1);
        chk({tag, "_data_all"}, 64'(dout === exp_data), 1);
        @(negedge clk);
        ena = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_clr_complt"}, complt, 0);
        chk({tag, "_clr_crcerr"}, crcerr, 0);
        chk({tag, "_clr_enderr"}, enderr, 0);
        chk({tag, "_data_kept"}, 64'(dout === exp_data), 1);
    endtask

    task automatic timeout_run(input logic [3:0] v, input string tag);
        @(negedge clk);
        ena = 1'b1;
        bus = v;
        @(posedge clk);
        repeat (TO) @(posedge clk);
        #1;
        chk({tag, "_tmo_early"}, tmo, 0);
        @(posedge clk);
        #1;
        chk({tag, "_tmo"}, tmo, 1);
        chk({tag, "_complt_early"}, complt, 0);
        chk({tag, "_busy"}, busy, 0);
        @(posedge clk);
        #1;
        chk({tag, "_complt"}, complt, 1);
        chk({tag, "_tmo_held"}, tmo, 1);
        @(negedge clk);
        ena = 1'b0;
        bus = 4'hF;
        @(posedge clk);
        #1;
        chk({tag, "_clr_tmo"}, tmo, 0);
        chk({tag, "_clr_complt"}, complt, 0);
    endtask

    initial begin
        rst = 1'b0;
        ena = 1'b0;
        bus = 4'hF;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_data", 64'(|dout), 0);
        chk("rst_complt", complt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_crcerr", crcerr, 0);
        chk("rst_enderr", enderr, 0);
        chk("rst_tmo", tmo, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        prepare(1'b0);
        send_block(-1, 4'b0000, 1'b0, "zero");

        prepare(1'b1);
        send_block(-1, 4'b0000, 1'b0, "ord");
        chk("ord_first", dout[4095:4092], 4'h0);
        chk("ord_second", dout[4091:4088], 4'h1);
        chk("ord_last", dout[3:0], 4'hF);

        prepare(1'b1);
        crc_tx[2] = crc_tx[2] ^ 16'h0080;
        send_block(-1, 4'b0100, 1'b0, "crc2");

        prepare(1'b1);
        end_nib = 4'b1011;
        send_block(-1, 4'b0000, 1'b1, "endbit");

        timeout_run(4'b1111, "to_ones");
        timeout_run(4'b0001, "to_part");

        prepare(1'b1);
        send_block(500, 4'b0000, 1'b0, "abort");
        repeat (3) @(negedge clk);
        send_block(-1, 4'b0000, 1'b0, "fresh");
        chk("fresh_last", dout[3:0], 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
